line_hit_ctrl: RTL and testbench

Collision and round controller that sits directly downstream of the six horizontal-line pixel generators. It watches each line's pixel output against the player cube's pixel during scan-out and decides at every frame boundary whether the cube touched a line. It also generates the `stop`, `flash`, `load_counter` and `start_machine` controls fed back to every line stage, and tracks the remaining lives.

---
 rtl/line_hit_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_line_hit_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_hit_ctrl.sv
// Collision and round controller for the six-line obstacle game: accumulates
// cube/line pixel overlap per frame and sequences IDLE/LOAD/PLAY/HIT/OVER.
module line_hit_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic       start_btn,
  input  logic       cube_px,
  input  logic [5:0] line_px,
  output logic       stop,
  output logic       flash,
  output logic       load_counter,
  output logic       start_machine,
  output logic       collision,
  output logic [2:0] hit_line,
  output logic [1:0] lives
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_HIT, S_OVER} state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES);

  state_t     state_q, state_d;
  logic       btn_q, btn_d;
  logic       pend_q, pend_d;
  logic       acc_q, acc_d;
  logic [5:0] acc_mask_q, acc_mask_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       stop_q, stop_d;
  logic       flash_q, flash_d;
  logic       load_q, load_d;
  logic       start_m_q, start_m_d;
  logic       coll_q, coll_d;
  logic [2:0] hit_line_q, hit_line_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] lowest_idx;
  logic       btn_rise;
  logic       can_start;

  // Priority encode from the top so the lowest set bit wins.
  always_comb begin
    lowest_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (acc_mask_q[i]) lowest_idx = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    btn_d       = start_btn;
    pend_d      = pend_q;
    frame_cnt_d = frame_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    hit_line_d  = hit_line_q;
    lives_d     = lives_q;
    coll_d      = 1'b0;
    stop_d      = 1'b0;
    load_d      = 1'b0;
    start_m_d   = 1'b0;
    btn_rise    = start_btn & ~btn_q;
    can_start   = (state_q == S_IDLE) || (state_q == S_OVER);

    if (frame) begin
      acc_d      = 1'b0;
      acc_mask_d = 6'd0;
    end else begin
      acc_d      = acc_q | (cube_px & (|line_px));
      acc_mask_d = acc_mask_q | ({6{cube_px}} & line_px);
    end

    if (btn_rise && can_start) pend_d = 1'b1;

    if (frame) begin
      unique case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            state_d = S_LOAD;
            pend_d  = 1'b0;
          end
        end
        S_LOAD: state_d = S_PLAY;
        S_PLAY: begin
          if (acc_q) begin
            state_d     = S_HIT;
            coll_d      = 1'b1;
            lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            hit_line_d  = lowest_idx;
            frame_cnt_d = 8'd0;
            flash_cnt_d = 8'd0;
          end
        end
        S_HIT: begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (flash_cnt_q + 8'd1 == FLASH_LAST) begin
            flash_cnt_d = 8'd0;
            flash_d     = ~flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
          end
          if (frame_cnt_q + 8'd1 == HIT_LAST) begin
            state_d = (lives_q == 2'd0) ? S_OVER : S_LOAD;
          end
        end
        S_OVER: begin
          if (pend_q) begin
            state_d = S_LOAD;
            pend_d  = 1'b0;
            lives_d = LIVES_INIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they follow the frame edge by one clk.
    unique case (state_d)
      S_PLAY: begin
        stop_d    = 1'b1;
        flash_d   = 1'b1;
        start_m_d = 1'b1;
      end
      S_HIT: begin
        start_m_d = 1'b1;
        if (state_q != S_HIT) flash_d = 1'b0;
      end
      S_OVER: flash_d = 1'b1;
      default: begin
        flash_d = 1'b1;
        load_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b0;
      pend_q      <= 1'b0;
      acc_q       <= 1'b0;
      acc_mask_q  <= 6'd0;
      frame_cnt_q <= 8'd0;
      flash_cnt_q <= 8'd0;
      stop_q      <= 1'b0;
      flash_q     <= 1'b1;
      load_q      <= 1'b1;
      start_m_q   <= 1'b0;
      coll_q      <= 1'b0;
      hit_line_q  <= 3'd0;
      lives_q     <= LIVES_INIT;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      acc_mask_q  <= acc_mask_d;
      frame_cnt_q <= frame_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      stop_q      <= stop_d;
      flash_q     <= flash_d;
      load_q      <= load_d;
      start_m_q   <= start_m_d;
      coll_q      <= coll_d;
      hit_line_q  <= hit_line_d;
      lives_q     <= lives_d;
    end
  end

  assign stop          = stop_q;
  assign flash         = flash_q;
  assign load_counter  = load_q;
  assign start_machine = start_m_q;
  assign collision     = coll_q;
  assign hit_line      = hit_line_q;
  assign lives         = lives_q;
endmodule

// File: tb/tb_line_hit_ctrl.sv
// Bench for line_hit_ctrl: a game-rule model checked every cycle, plus directed
// literal expectations on the key scenarios.
module tb_line_hit_ctrl;
  localparam int LV = 3;
  localparam int HF = 60;
  localparam int FF = 8;
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_HIT = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame = 1'b0;
  logic       start_btn = 1'b0;
  logic       cube_px = 1'b0;
  logic [5:0] line_px = 6'd0;
  logic       stop, flash, load_counter, start_machine, collision;
  logic [2:0] hit_line;
  logic [1:0] lives;

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  line_hit_ctrl #(.LIVES(LV), .HIT_FRAMES(HF), .FLASH_FRAMES(FF)) dut (
    .clk(clk), .reset(reset), .frame(frame), .start_btn(start_btn),
    .cube_px(cube_px), .line_px(line_px), .stop(stop), .flash(flash),
    .load_counter(load_counter), .start_machine(start_machine),
    .collision(collision), .hit_line(hit_line), .lives(lives)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game-rule model: mode, lives and frames elapsed since entering HIT.
  int  m_mode, m_lives, m_hitk, m_hit_line, old_mode;
  bit  m_pend, m_btn, m_acc, m_coll, rise, consumed;
  bit  [5:0] m_mask;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_mode = M_IDLE; m_lives = LV; m_hitk = 0; m_hit_line = 0;
        m_pend = 0; m_btn = 0; m_acc = 0; m_coll = 0; m_mask = 0;
      end else begin
        rise = start_btn && !m_btn;
        m_btn = start_btn;
        old_mode = m_mode;
        consumed = 0;
        m_coll = 0;
        if (frame) begin
          case (m_mode)
            M_IDLE: if (m_pend) begin m_mode = M_LOAD; m_pend = 0; consumed = 1; end
            M_LOAD: m_mode = M_PLAY;
            M_PLAY: if (m_acc) begin
              m_mode = M_HIT; m_coll = 1; m_hitk = 0;
              m_lives = (m_lives > 0) ? m_lives - 1 : 0;
              for (int i = 5; i >= 0; i--) if (m_mask[i]) m_hit_line = i;
            end
            M_HIT: begin
              m_hitk++;
              if (m_hitk == HF) m_mode = (m_lives == 0) ? M_OVER : M_LOAD;
            end
            default: if (m_pend) begin
              m_mode = M_LOAD; m_pend = 0; consumed = 1; m_lives = LV;
            end
          endcase
          m_acc = 0;
          m_mask = 0;
        end else begin
          if (cube_px) begin
            m_mask |= line_px;
            if (line_px != 0) m_acc = 1;
          end
        end
        if (rise && (old_mode == M_IDLE || old_mode == M_OVER) && !consumed) m_pend = 1;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("m_stop", 8'(stop), 8'(m_mode == M_PLAY));
        chk("m_load", 8'(load_counter), 8'(m_mode == M_IDLE || m_mode == M_LOAD));
        chk("m_start_machine", 8'(start_machine), 8'(m_mode == M_PLAY || m_mode == M_HIT));
        chk("m_flash", 8'(flash), 8'((m_mode == M_HIT) ? ((m_hitk / FF) % 2) : 1));
        chk("m_collision", 8'(collision), 8'(m_coll));
        chk("m_hit_line", 8'(hit_line), 8'(m_hit_line));
        chk("m_lives", 8'(lives), 8'(m_lives));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_frame(input int gap);
    repeat (gap) cyc();
    frame = 1'b1;
    cyc();
    frame = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  task automatic hit(input logic [5:0] lp);
    cube_px = 1'b1;
    line_px = lp;
    repeat (10) cyc();
    cube_px = 1'b0;
    line_px = 6'd0;
    do_frame(3);
  endtask

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_stop", 8'(stop), 8'd0);
    chk("rst_flash", 8'(flash), 8'd1);
    chk("rst_load", 8'(load_counter), 8'd1);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_hit_line", 8'(hit_line), 8'd0);

    do_frame(4);
    chk("idle_no_pend", 8'(load_counter), 8'd1);

    press();
    do_frame(4);
    chk("load_load", 8'(load_counter), 8'd1);
    chk("load_sm", 8'(start_machine), 8'd0);
    do_frame(4);
    chk("play_stop", 8'(stop), 8'd1);
    chk("play_load", 8'(load_counter), 8'd0);
    chk("play_lives", 8'(lives), 8'd3);

    // Cube over empty space, then overlap only on the frame cycle: no hit.
    cube_px = 1'b1;
    repeat (10) cyc();
    cube_px = 1'b0;
    do_frame(2);
    chk("no_line_coll", 8'(collision), 8'd0);
    cube_px = 1'b1; line_px = 6'b111111; frame = 1'b1;
    cyc();
    cube_px = 1'b0; line_px = 6'd0; frame = 1'b0;
    do_frame(3);
    chk("frame_px_coll", 8'(collision), 8'd0);
    chk("frame_px_stop", 8'(stop), 8'd1);

    hit(6'b101000);
    chk("hit1_coll", 8'(collision), 8'd1);
    chk("hit1_line", 8'(hit_line), 8'd3);
    chk("hit1_lives", 8'(lives), 8'd2);
    chk("hit1_stop", 8'(stop), 8'd0);
    chk("hit1_flash", 8'(flash), 8'd0);
    cyc();
    chk("hit1_coll_end", 8'(collision), 8'd0);

    repeat (7) do_frame(3);
    chk("flash_f7", 8'(flash), 8'd0);
    do_frame(3);
    chk("flash_f8", 8'(flash), 8'd1);
    repeat (8) do_frame(3);
    chk("flash_f16", 8'(flash), 8'd0);
    repeat (43) do_frame(3);
    chk("hit_f59_stop", 8'(stop), 8'd0);
    chk("hit_f59_load", 8'(load_counter), 8'd0);
    do_frame(3);
    chk("hit_f60_load", 8'(load_counter), 8'd1);
    do_frame(3);
    chk("hit_f61_play", 8'(stop), 8'd1);

    // Multi-line hit, then reset coincident with frame during HIT.
    hit(6'b010001);
    chk("hit2_line", 8'(hit_line), 8'd0);
    chk("hit2_lives", 8'(lives), 8'd1);
    repeat (5) do_frame(3);
    reset = 1'b1; frame = 1'b1;
    cyc();
    reset = 1'b0; frame = 1'b0;
    chk("rst2_lives", 8'(lives), 8'd3);
    chk("rst2_load", 8'(load_counter), 8'd1);
    chk("rst2_sm", 8'(start_machine), 8'd0);
    chk("rst2_hit_line", 8'(hit_line), 8'd0);

    press();
    do_frame(3);
    do_frame(3);
    hit(6'b100000);
    chk("hitA_line", 8'(hit_line), 8'd5);
    repeat (61) do_frame(3);
    hit(6'b000110);
    chk("hitB_lives", 8'(lives), 8'd1);
    repeat (61) do_frame(3);
    hit(6'b000100);
    chk("hitC_lives", 8'(lives), 8'd0);
    press();
    repeat (60) do_frame(3);
    chk("over_load", 8'(load_counter), 8'd0);
    chk("over_sm", 8'(start_machine), 8'd0);
    chk("over_lives", 8'(lives), 8'd0);
    do_frame(3);
    chk("over_stays", 8'(load_counter), 8'd0);

    // Start edge on the frame cycle takes effect one frame later.
    frame = 1'b1; start_btn = 1'b1;
    cyc();
    frame = 1'b0; start_btn = 1'b0;
    chk("over_frame_btn", 8'(load_counter), 8'd0);
    do_frame(3);
    chk("reload_load", 8'(load_counter), 8'd1);
    chk("reload_lives", 8'(lives), 8'd3);
    do_frame(3);
    chk("reload_play", 8'(stop), 8'd1);
    repeat (3) cyc();

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
